// File: rtl/matvec_mac_seq.sv
// rtl/matvec_mac_seq.sv - time-multiplexed fixed-point matrix-vector engine y = W*x + b
//
// Computes y = W*x + b for an NROW x NCOL signed Q(QN.QM) matrix using NMAC
// shared multipliers, each serving LANES rows in successive passes over the
// columns. The result is rounded half-up per product and saturated on output.
//
// Ports:
//   clk          clock
//   reset        synchronous active-high reset, aborts any computation
//   start        request a computation (sampled only in IDLE)
//   weightRow    column colAddress of W, row r at [r*BITWIDTH +: BITWIDTH]
//   inputVector  x[colAddress]
//   bias         b vector, captured on the start-accept edge
//   busy         high from start-accept until dataReady
//   colAddress   combinational-read memory address
//   dataReady    single-cycle pulse, outputVector valid
//   outputVector saturated result, same element layout as weightRow

module matvec_mac_seq #(
    parameter int NROW          = 16,
    parameter int NCOL          = 16,
    parameter int QN            = 6,
    parameter int QM            = 11,
    parameter int BITWIDTH      = QN + QM + 1,
    parameter int LANES         = 2,
    parameter int NMAC          = NROW / LANES,
    parameter int ADDR_BITWIDTH = 4,
    parameter int ACC_BITWIDTH  = BITWIDTH + ADDR_BITWIDTH + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NROW*BITWIDTH-1:0]     weightRow,
    input  logic [BITWIDTH-1:0]          inputVector,
    input  logic [NROW*BITWIDTH-1:0]     bias,
    output logic                         busy,
    output logic [ADDR_BITWIDTH-1:0]     colAddress,
    output logic                         dataReady,
    output logic [NROW*BITWIDTH-1:0]     outputVector
);

    localparam int PROD_W = 2 * BITWIDTH;
    // A full-scale product shifted by QM already needs PROD_W-QM bits, so the
    // accumulator is widened to hold NCOL of them plus bias without wrapping.
    localparam int SAFE_W = PROD_W - QM + ADDR_BITWIDTH + 1;
    localparam int ACC_W  = (ACC_BITWIDTH > SAFE_W) ? ACC_BITWIDTH : SAFE_W;
    localparam int PASS_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] SAT  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic signed [PROD_W-1:0] RND     = PROD_W'(1) << (QM - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX = {{(ACC_W-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  SAT_MIN = {{(ACC_W-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

    logic [1:0]                 state;
    logic [PASS_W-1:0]          pass;
    logic signed [ACC_W-1:0]    acc   [NROW];
    logic signed [BITWIDTH-1:0] w_sel [NMAC];
    logic signed [PROD_W-1:0]   prod  [NMAC];
    logic signed [ACC_W-1:0]    inc   [NMAC];

    // Multiplier k serves rows k*LANES .. k*LANES+LANES-1; pass picks which one.
    always_comb begin
        for (int k = 0; k < NMAC; k++) begin
            w_sel[k] = weightRow[(k*LANES + int'(pass))*BITWIDTH +: BITWIDTH];
            prod[k]  = w_sel[k] * $signed(inputVector);
            inc[k]   = ACC_W'((prod[k] + RND) >>> QM);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            colAddress   <= '0;
            pass         <= '0;
            busy         <= 1'b0;
            dataReady    <= 1'b0;
            outputVector <= '0;
            for (int r = 0; r < NROW; r++) acc[r] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dataReady <= 1'b0;
                    if (start) begin
                        state      <= CALC;
                        busy       <= 1'b1;
                        colAddress <= '0;
                        pass       <= '0;
                        for (int r = 0; r < NROW; r++)
                            acc[r] <= ACC_W'($signed(bias[r*BITWIDTH +: BITWIDTH]));
                    end
                end
                CALC: begin
                    for (int r = 0; r < NROW; r++)
                        if (PASS_W'(r % LANES) == pass)
                            acc[r] <= acc[r] + inc[r / LANES];
                    if (colAddress == ADDR_BITWIDTH'(NCOL - 1)) begin
                        colAddress <= '0;
                        if (pass == PASS_W'(LANES - 1)) begin
                            pass  <= '0;
                            state <= SAT;
                        end else begin
                            pass <= pass + 1'b1;
                        end
                    end else begin
                        colAddress <= colAddress + 1'b1;
                    end
                end
                SAT: begin
                    for (int r = 0; r < NROW; r++) begin
                        if (acc[r] > SAT_MAX)
                            outputVector[r*BITWIDTH +: BITWIDTH] <= SAT_MAX[BITWIDTH-1:0];
                        else if (acc[r] < SAT_MIN)
                            outputVector[r*BITWIDTH +: BITWIDTH] <= SAT_MIN[BITWIDTH-1:0];
                        else
                            outputVector[r*BITWIDTH +: BITWIDTH] <= acc[r][BITWIDTH-1:0];
                    end
                    dataReady <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    dataReady  <= 1'b0;
                    colAddress <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
